// File: rtl/mem_march_seq.sv
// March C- command sequencer for the memory-under-test path. Host commands pass
// through while idle and are dropped (with a host_drop pulse) while a test runs.
module mem_march_seq #(
    parameter int unsigned GAP     = 2,
    parameter logic [6:0]  WR_MODE = 7'h02,
    parameter logic [6:0]  RD_MODE = 7'h03
) (
    input  logic        core_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] addr_lo,
    input  logic [15:0] addr_hi,
    input  logic [7:0]  pattern,
    input  logic [31:0] host_data,
    input  logic        host_valid,
    output logic [31:0] cmd_data,
    output logic        cmd_valid,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic        cfg_err,
    output logic [2:0]  elem,
    output logic        host_drop
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

    localparam int unsigned GAP_M1   = (GAP == 0) ? 0 : GAP - 1;
    localparam logic [3:0]  GAP_LOAD = GAP_M1[3:0];

    state_t      state_q;
    logic [2:0]  elem_q, elem_d;
    logic        op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] addrLo_q, addrHi_q;
    logic [7:0]  pattern_q;
    logic [3:0]  gapCnt_q;
    logic        lastCmd_q;
    logic [31:0] cmdData_q;
    logic        cmdValid_q, busy_q, done_q, aborted_q, cfgErr_q, hostDrop_q;

    logic lastOp, goingDown, atEnd, seqEnd, stopNow;

    // Reads carry the expected value and flag d1 in bit 31 so the inverted
    // readback always compares against the background pattern.
    function automatic logic [31:0] buildCmd(input logic [2:0]  e,
                                             input logic        o,
                                             input logic [15:0] a,
                                             input logic [7:0]  pat);
        logic       isRead;
        logic       useD1;
        logic [7:0] data;
        isRead = (e != 3'd0) && !o;
        case (e)
            3'd1, 3'd3: useD1 = o;
            3'd2, 3'd4: useD1 = !o;
            default:    useD1 = 1'b0;
        endcase
        data = useD1 ? ~pat : pat;
        if (isRead) buildCmd = {useD1, RD_MODE, a, data};
        else        buildCmd = {1'b0, WR_MODE, a, data};
    endfunction

    // Position after the current command: op first, then address, then element.
    always_comb begin
        elem_d    = elem_q;
        op_d      = op_q;
        addr_d    = addr_q;
        seqEnd    = 1'b0;
        lastOp    = (elem_q == 3'd0 || elem_q == 3'd5) ? 1'b1 : op_q;
        goingDown = (elem_q == 3'd3 || elem_q == 3'd4);
        atEnd     = goingDown ? (addr_q == addrLo_q) : (addr_q == addrHi_q);
        if (!lastOp) begin
            op_d = 1'b1;
        end else begin
            op_d = 1'b0;
            if (!atEnd) begin
                addr_d = goingDown ? addr_q - 16'd1 : addr_q + 16'd1;
            end else if (elem_q == 3'd5) begin
                seqEnd = 1'b1;
            end else begin
                elem_d = elem_q + 3'd1;
                addr_d = (elem_d == 3'd3 || elem_d == 3'd4) ? addrHi_q : addrLo_q;
            end
        end
    end

    always_comb begin
        stopNow = 1'b0;
        case (state_q)
            ISSUE:   stopNow = abort || (seqEnd && (GAP == 0));
            WAIT:    stopNow = abort || (gapCnt_q == 4'd0 && lastCmd_q);
            default: stopNow = 1'b0;
        endcase
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            elem_q     <= 3'd0;
            op_q       <= 1'b0;
            addr_q     <= 16'd0;
            addrLo_q   <= 16'd0;
            addrHi_q   <= 16'd0;
            pattern_q  <= 8'd0;
            gapCnt_q   <= 4'd0;
            lastCmd_q  <= 1'b0;
            cmdData_q  <= 32'd0;
            cmdValid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            cfgErr_q   <= 1'b0;
            hostDrop_q <= 1'b0;
        end else begin
            cmdValid_q <= 1'b0;
            done_q     <= 1'b0;
            hostDrop_q <= 1'b0;
            if (stopNow) begin
                state_q    <= FIN;
                busy_q     <= 1'b0;
                done_q     <= 1'b0 | 1'b1;
                elem_q     <= 3'd0;
                aborted_q  <= abort;
                hostDrop_q <= host_valid;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            aborted_q  <= 1'b0;
                            cfgErr_q   <= 1'b0;
                            addrLo_q   <= addr_lo;
                            addrHi_q   <= addr_hi;
                            pattern_q  <= pattern;
                            hostDrop_q <= host_valid;
                            if (addr_lo > addr_hi) begin
                                cfgErr_q <= 1'b1;
                                done_q   <= 1'b1;
                                state_q  <= FIN;
                            end else begin
                                elem_q     <= 3'd0;
                                op_q       <= 1'b0;
                                addr_q     <= addr_lo;
                                lastCmd_q  <= 1'b0;
                                busy_q     <= 1'b1;
                                cmdData_q  <= buildCmd(3'd0, 1'b0, addr_lo, pattern);
                                cmdValid_q <= 1'b1;
                                state_q    <= ISSUE;
                            end
                        end else if (host_valid) begin
                            cmdData_q  <= host_data;
                            cmdValid_q <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        hostDrop_q <= host_valid;
                        elem_q     <= elem_d;
                        op_q       <= op_d;
                        addr_q     <= addr_d;
                        if (seqEnd) begin
                            lastCmd_q <= 1'b1;
                            gapCnt_q  <= GAP_LOAD;
                            state_q   <= WAIT;
                        end else if (GAP == 0) begin
                            cmdData_q  <= buildCmd(elem_d, op_d, addr_d, pattern_q);
                            cmdValid_q <= 1'b1;
                        end else begin
                            gapCnt_q <= GAP_LOAD;
                            state_q  <= WAIT;
                        end
                    end
                    WAIT: begin
                        hostDrop_q <= host_valid;
                        if (gapCnt_q == 4'd0) begin
                            cmdData_q  <= buildCmd(elem_q, op_q, addr_q, pattern_q);
                            cmdValid_q <= 1'b1;
                            state_q    <= ISSUE;
                        end else begin
                            gapCnt_q <= gapCnt_q - 4'd1;
                        end
                    end
                    FIN: begin
                        state_q <= IDLE;
                        if (host_valid) begin
                            cmdData_q  <= host_data;
                            cmdValid_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign cmd_data  = cmdData_q;
    assign cmd_valid = cmdValid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign cfg_err   = cfgErr_q;
    assign elem      = elem_q;
    assign host_drop = hostDrop_q;

endmodule
